pll_cfg_shadow: RTL

Register-mapped shadow/commit stage that sits directly upstream of the PLL map core. A simple word-write/read bus from the SPI/host bridge writes 32-bit configuration words into a shadow bank. A commit write then atomically publishes the assembled `pllMap_pkg::pllmap2pll` struct together with a one-cycle `valid` strobe, and the map core consumes both. The block guarantees the map core never sees a partially updated configuration and enforces a guard interval between commits.

---
 rtl/pllMap_pkg.sv | 137 +++++++++++++
 rtl/pll_cfg_shadow_guard_fsm.sv | 76 +++++++
 rtl/pll_cfg_shadow.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pllMap_pkg.sv
// pllMap_pkg: PLL map configuration struct, shadow word layout, write masks,
// reset image and pack/unpack helpers shared by the shadow/commit stage.
// Optional build macro PLL_CFG_LOCK_EN makes CTRL bit 30 a writable LOCK bit.
package pllMap_pkg;

    // Word indices of the shadow bank
    localparam int PLLCFG_CTRL   = 0;
    localparam int PLLCFG_RATIO  = 1;
    localparam int PLLCFG_ZDIV   = 2;
    localparam int PLLCFG_FZ0    = 3;
    localparam int PLLCFG_FZ1    = 4;
    localparam int PLLCFG_FZ2    = 5;
    localparam int PLLCFG_FZ3    = 6;
    localparam int PLLCFG_DFX    = 7;
    localparam int PLLCFG_SSC0   = 8;
    localparam int PLLCFG_SSC1   = 9;
    localparam int PLLCFG_NWORDS = 10;

    // CTRL bit that requests a commit; it is never stored
    localparam int PLLCFG_COMMIT_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_GUARD  = 2'd2
    } guard_state_e;

    typedef struct packed {
        logic        pllen;
        logic        en_write;
        logic        en_read;
        logic        bypass;
        logic        ldo_enable;
        logic        clkpostdist;
        logic        pllfwen_b;
        logic        ssc_en;
        logic [9:0]  ratio;
        logic [9:0]  zdiv0_ratio;
        logic [9:0]  zdiv1_ratio;
        logic [10:0] fz_vcotrim;
        logic [7:0]  fz_cp1trim;
        logic [7:0]  fz_cp2trim;
        logic [5:0]  fz_lftrim;
        logic [5:0]  fz_irefgen;
        logic [3:0]  fz_tdctrim;
        logic [3:0]  fz_dcotrim;
        logic        powergood_vnn;
        logic [3:0]  dfx_sel;
        logic [23:0] ssc_frac_step;
        logic [8:0]  ssc_cyc_to_peak_m1;
    } pllmap2pll;

    typedef logic [PLLCFG_NWORDS-1:0][31:0] pllcfg_words_t;
    typedef logic [31:0] pllcfg_mask_t [PLLCFG_NWORDS];

    localparam pllmap2pll PLLMAP_DEFAULT = '{
        pllen:              1'b1,
        en_write:           1'b0,
        en_read:            1'b0,
        bypass:             1'b0,
        ldo_enable:         1'b0,
        clkpostdist:        1'b0,
        pllfwen_b:          1'b0,
        ssc_en:             1'b0,
        ratio:              10'hBC,
        zdiv0_ratio:        10'hC7,
        zdiv1_ratio:        10'h19,
        fz_vcotrim:         11'h3C9,
        fz_cp1trim:         8'h0A,
        fz_cp2trim:         8'h0C,
        fz_lftrim:          6'h15,
        fz_irefgen:         6'h20,
        fz_tdctrim:         4'h8,
        fz_dcotrim:         4'h7,
        powergood_vnn:      1'b1,
        dfx_sel:            4'h0,
        ssc_frac_step:      24'hE6829A,
        ssc_cyc_to_peak_m1: 9'h1D8
    };

`ifdef PLL_CFG_LOCK_EN
    localparam logic [31:0] PLLCFG_CTRL_MASK = 32'h4000_00FF;
`else
    localparam logic [31:0] PLLCFG_CTRL_MASK = 32'h0000_00FF;
`endif

    // Storable bits per word; everything else is reserved and reads 0
    localparam pllcfg_mask_t PLLCFG_WMASK = '{
        PLLCFG_CTRL_MASK, 32'h0000_03FF, 32'h03FF_03FF, 32'h0000_07FF, 32'h0000_FFFF,
        32'h0000_3F3F,    32'h0000_0F0F, 32'h0000_001F, 32'h00FF_FFFF, 32'h0000_01FF
    };

    // Build the published struct from the shadow words
    function automatic pllmap2pll pllcfg_pack(input pllcfg_words_t w);
        pllmap2pll m;
        m = '0;
        {m.ssc_en, m.pllfwen_b, m.clkpostdist, m.ldo_enable,
         m.bypass, m.en_read, m.en_write, m.pllen}  = w[PLLCFG_CTRL][7:0];
        m.ratio              = w[PLLCFG_RATIO][9:0];
        m.zdiv0_ratio        = w[PLLCFG_ZDIV][9:0];
        m.zdiv1_ratio        = w[PLLCFG_ZDIV][25:16];
        m.fz_vcotrim         = w[PLLCFG_FZ0][10:0];
        m.fz_cp1trim         = w[PLLCFG_FZ1][7:0];
        m.fz_cp2trim         = w[PLLCFG_FZ1][15:8];
        m.fz_lftrim          = w[PLLCFG_FZ2][5:0];
        m.fz_irefgen         = w[PLLCFG_FZ2][13:8];
        m.fz_tdctrim         = w[PLLCFG_FZ3][3:0];
        m.fz_dcotrim         = w[PLLCFG_FZ3][11:8];
        m.powergood_vnn      = w[PLLCFG_DFX][0];
        m.dfx_sel            = w[PLLCFG_DFX][4:1];
        m.ssc_frac_step      = w[PLLCFG_SSC0][23:0];
        m.ssc_cyc_to_peak_m1 = w[PLLCFG_SSC1][8:0];
        return m;
    endfunction

    // Extract one shadow word image from the struct
    function automatic logic [31:0] pllcfg_word(input pllmap2pll m, input int idx);
        logic [31:0] w;
        w = 32'h0;
        case (idx)
            PLLCFG_CTRL:  w[7:0]   = {m.ssc_en, m.pllfwen_b, m.clkpostdist, m.ldo_enable,
                                      m.bypass, m.en_read, m.en_write, m.pllen};
            PLLCFG_RATIO: w[9:0]   = m.ratio;
            PLLCFG_ZDIV:  w        = {6'h0, m.zdiv1_ratio, 6'h0, m.zdiv0_ratio};
            PLLCFG_FZ0:   w[10:0]  = m.fz_vcotrim;
            PLLCFG_FZ1:   w[15:0]  = {m.fz_cp2trim, m.fz_cp1trim};
            PLLCFG_FZ2:   w[13:0]  = {2'h0, m.fz_irefgen, 2'h0, m.fz_lftrim};
            PLLCFG_FZ3:   w[11:0]  = {m.fz_dcotrim, 4'h0, m.fz_tdctrim};
            PLLCFG_DFX:   w[4:0]   = {m.dfx_sel, m.powergood_vnn};
            PLLCFG_SSC0:  w[23:0]  = m.ssc_frac_step;
            PLLCFG_SSC1:  w[8:0]   = m.ssc_cyc_to_peak_m1;
            default:      w        = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pll_cfg_shadow_guard_fsm.sv
// pll_cfg_guard_fsm: IDLE -> COMMIT (1 cycle) -> GUARD (GUARD_CYCLES cycles)
// sequencer. Produces the bus accept window, the commit strobe and busy.
module pll_cfg_guard_fsm
    import pllMap_pkg::*;
#(
    parameter int GUARD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic commit,
    output logic accept,
    output logic valid,
    output logic busy
);

    guard_state_e state_r;
    guard_state_e state_nxt_s;
    logic [7:0]   cnt_r;
    logic [7:0]   cnt_nxt_s;
    logic         valid_r;
    logic         busy_r;

    // State, guard counter and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            valid_r <= (state_nxt_s == ST_COMMIT);
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Next-state and counter decode; an unused encoding falls back to IDLE
    always_comb begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (commit) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_GUARD;
                cnt_nxt_s   = 8'(GUARD_CYCLES - 1);
            end
            ST_GUARD: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GUARD;
                    cnt_nxt_s   = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Outputs: bus accepted only in IDLE, strobes come straight from flops
    always_comb begin
        accept = (state_r == ST_IDLE);
        valid  = valid_r;
        busy   = busy_r;
    end

endmodule

// File: rtl/pll_cfg_shadow.sv
// pll_cfg_shadow: shadow bank of PLL configuration words with an atomic
// commit into the published pllmap2pll register and a post-commit guard.
// Optional build macro PLL_CFG_LOCK_EN adds the sticky CTRL LOCK bit (30).
module pll_cfg_shadow
    import pllMap_pkg::*;
#(
    parameter int NUM_WORDS    = 16,
    parameter int GUARD_CYCLES = 8,
    localparam int AW          = $clog2(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          gnt_o,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          valid_o,
    output pllmap2pll     pllmap_o,
    output logic          busy_o
);

    pllcfg_words_t shadow_r;
    pllcfg_words_t shadow_nxt_s;
    pllmap2pll     pllmap_r;
    logic          accept_s;
    logic          gnt_s;
    logic          in_range_s;
    logic          is_ctrl_s;
    logic          locked_s;
    logic          wr_ok_s;
    logic          commit_s;
    logic          err_s;
    logic [31:0]   rd_word_s;
    logic          rvalid_r;
    logic [31:0]   rdata_r;
    logic          err_r;

    pll_cfg_guard_fsm #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guard_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .commit (commit_s),
        .accept (accept_s),
        .valid  (valid_o),
        .busy   (busy_o)
    );

    // Bus decode: grant, range check, lock protection and commit detect
    always_comb begin
        gnt_s      = req_i & accept_s;
        in_range_s = (32'(addr_i) < 32'(NUM_WORDS));
        is_ctrl_s  = (addr_i == {AW{1'b0}});
`ifdef PLL_CFG_LOCK_EN
        locked_s   = shadow_r[PLLCFG_CTRL][30];
`else
        locked_s   = 1'b0;
`endif
        wr_ok_s    = gnt_s & we_i & in_range_s & (~locked_s | is_ctrl_s);
        commit_s   = gnt_s & we_i & is_ctrl_s & wdata_i[PLLCFG_COMMIT_BIT];
        err_s      = ~in_range_s | (we_i & locked_s & ~is_ctrl_s);
    end

    // Masked write into the shadow image and read mux; locked CTRL keeps only pllen
    always_comb begin
        logic [31:0] wmask;
        shadow_nxt_s = shadow_r;
        rd_word_s    = 32'h0;
        wmask        = 32'h0;
        for (int i = 0; i < PLLCFG_NWORDS; i++) begin
            if (32'(addr_i) == 32'(i)) begin
                if (locked_s) begin
                    wmask = (i == PLLCFG_CTRL) ? 32'h0000_0001 : 32'h0;
                end else begin
                    wmask = PLLCFG_WMASK[i];
                end
                rd_word_s = shadow_r[i];
                if (wr_ok_s) begin
                    shadow_nxt_s[i] = (shadow_r[i] & ~wmask) | (wdata_i & wmask);
                end else begin
                    shadow_nxt_s[i] = shadow_r[i];
                end
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Shadow bank flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PLLCFG_NWORDS; i++) begin
                shadow_r[i] <= pllcfg_word(PLLMAP_DEFAULT, i);
            end
        end else begin
            shadow_r <= shadow_nxt_s;
        end
    end

    // Published configuration: loads the post-write image only on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pllmap_r <= PLLMAP_DEFAULT;
        end else if (commit_s) begin
            pllmap_r <= pllcfg_pack(shadow_nxt_s);
        end else begin
            pllmap_r <= pllmap_r;
        end
    end

    // Registered bus response, one cycle after the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= gnt_s;
            err_r    <= gnt_s & err_s;
            rdata_r  <= (gnt_s & ~we_i & in_range_s) ? rd_word_s : 32'h0;
        end
    end

    // Output wiring
    always_comb begin
        gnt_o    = gnt_s;
        rvalid_o = rvalid_r;
        rdata_o  = rdata_r;
        err_o    = err_r;
        pllmap_o = pllmap_r;
    end

endmodule
